// File: rtl/dispatch_ctrl_pkg.sv
// Shared encodings for the dispatch controller: instruction classes, FSM states
// and the debug view of the controller.
package dispatch_ctrl_pkg;

    localparam int ROB_TAG_W = 4;

    localparam logic [1:0] CLASS_ALU = 2'd0;
    localparam logic [1:0] CLASS_MEM = 2'd1;
    localparam logic [1:0] CLASS_BR  = 2'd2;
    localparam logic [1:0] CLASS_ILL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        state_e state;
        logic   rob_empty;
        logic   rs_empty;
        logic   lsb_empty;
    } dbg_t;

endpackage

// File: rtl/dispatch_ctrl_credit_counter.sv
// Occupancy counter for one back-end resource; a decrement at zero is dropped
// and reported on underflow instead of wrapping.
module credit_counter #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic clr,
    input  logic sync_clr,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty,
    output logic underflow
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (sync_clr) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(inc) - CW'(dec & ~empty);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign underflow = dec & empty & ~sync_clr;

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: gates decoder acceptance on ROB/RS/LSB credits, hands out
// ROB tags for renaming, and runs a timed flush after a mispredict.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int ROB_DEPTH  = 1 << ROB_TAG_W,
    parameter int RS_DEPTH   = 8,
    parameter int LSB_DEPTH  = 8,
    parameter int FLUSH_WAIT = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 rdy,
    input  logic                 inst_valid,
    input  logic [1:0]           inst_class,
    input  logic                 inst_has_rd,
    output logic                 inst_accept,
    output logic                 rob_alloc,
    output logic [ROB_TAG_W-1:0] rob_tail_tag,
    output logic                 rs_alloc,
    output logic                 lsb_alloc,
    output logic                 rat_write,
    input  logic                 rob_commit,
    input  logic                 rs_free,
    input  logic                 lsb_free,
    input  logic                 flush,
    output logic                 flushing,
    output logic                 illegal_inst,
    output logic                 underflow_err,
    output dbg_t                 dbg
);

    localparam int FC_W = (FLUSH_WAIT > 1) ? $clog2(FLUSH_WAIT) : 1;

    state_e               state_q, state_d;
    logic [FC_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic [ROB_TAG_W-1:0] tail_q, tail_d;
    logic                 illegal_q, illegal_d;
    logic                 underflow_q, underflow_d;

    logic is_mem, is_ill, target_full, flush_take, credit_en, accept;
    logic rob_full, rs_full, lsb_full;
    logic rob_empty, rs_empty, lsb_empty;
    logic rob_uf, rs_uf, lsb_uf;

    assign is_mem      = (inst_class == CLASS_MEM);
    assign is_ill      = (inst_class == CLASS_ILL);
    assign target_full = is_mem ? lsb_full : rs_full;

    // A flush is only honoured once running; it outranks every other event.
    assign flush_take = rdy & flush & ((state_q == ST_RUN) | (state_q == ST_FLUSH));
    assign credit_en  = rdy & (state_q != ST_FLUSH) & ~flush_take;

    assign accept = rdy & (state_q == ST_RUN) & ~flush & inst_valid & ~is_ill
                  & ~rob_full & ~target_full;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (rdy) begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN: begin
                    if (flush) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FC_W'(FLUSH_WAIT - 1);
                    end
                end
                ST_FLUSH: begin
                    if (flush) begin
                        flush_cnt_d = FC_W'(FLUSH_WAIT - 1);
                    end else if (flush_cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tail_d      = tail_q;
        illegal_d   = illegal_q;
        underflow_d = underflow_q;
        if (flush_take) begin
            tail_d = '0;
        end else if (accept) begin
            tail_d = tail_q + 1'b1;
        end
        if (rdy & (state_q == ST_RUN) & inst_valid & is_ill) begin
            illegal_d = 1'b1;
        end
        if (rob_uf | rs_uf | lsb_uf) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            tail_q      <= '0;
            illegal_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tail_q      <= tail_d;
            illegal_q   <= illegal_d;
            underflow_q <= underflow_d;
        end
    end

    credit_counter #(.DEPTH(ROB_DEPTH)) u_rob_cnt (
        .clk       (clk),
        .clr       (clr),
        .sync_clr  (flush_take),
        .inc       (accept),
        .dec       (credit_en & rob_commit),
        .full      (rob_full),
        .empty     (rob_empty),
        .underflow (rob_uf)
    );

    credit_counter #(.DEPTH(RS_DEPTH)) u_rs_cnt (
        .clk       (clk),
        .clr       (clr),
        .sync_clr  (flush_take),
        .inc       (accept & ~is_mem),
        .dec       (credit_en & rs_free),
        .full      (rs_full),
        .empty     (rs_empty),
        .underflow (rs_uf)
    );

    credit_counter #(.DEPTH(LSB_DEPTH)) u_lsb_cnt (
        .clk       (clk),
        .clr       (clr),
        .sync_clr  (flush_take),
        .inc       (accept & is_mem),
        .dec       (credit_en & lsb_free),
        .full      (lsb_full),
        .empty     (lsb_empty),
        .underflow (lsb_uf)
    );

    // Every output is forced low while rdy is low.
    assign inst_accept   = accept;
    assign rob_alloc     = accept;
    assign rs_alloc      = accept & ~is_mem;
    assign lsb_alloc     = accept & is_mem;
    assign rat_write     = accept & inst_has_rd;
    assign rob_tail_tag  = rdy ? tail_q : '0;
    assign flushing      = rdy & (state_q == ST_FLUSH);
    assign illegal_inst  = rdy & illegal_q;
    assign underflow_err = rdy & underflow_q;
    assign dbg           = rdy ? '{state: state_q, rob_empty: rob_empty,
                                   rs_empty: rs_empty, lsb_empty: lsb_empty}
                               : '0;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: expected ROB tags are queued when an accept
// is expected and popped when the DUT reports one.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  localparam int ROB_DEPTH = 16;

  logic clk = 1'b0;
  logic clr, rdy;
  logic inst_valid, inst_has_rd;
  logic [1:0] inst_class;
  logic inst_accept, rob_alloc, rs_alloc, lsb_alloc, rat_write;
  logic [ROB_TAG_W-1:0] rob_tail_tag;
  logic rob_commit, rs_free, lsb_free, flush;
  logic flushing, illegal_inst, underflow_err;
  dbg_t dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [ROB_TAG_W-1:0] exp_q[$];
  int tail_m = 0;

  dispatch_ctrl dut (
    .clk(clk), .clr(clr), .rdy(rdy),
    .inst_valid(inst_valid), .inst_class(inst_class), .inst_has_rd(inst_has_rd),
    .inst_accept(inst_accept), .rob_alloc(rob_alloc), .rob_tail_tag(rob_tail_tag),
    .rs_alloc(rs_alloc), .lsb_alloc(lsb_alloc), .rat_write(rat_write),
    .rob_commit(rob_commit), .rs_free(rs_free), .lsb_free(lsb_free),
    .flush(flush), .flushing(flushing), .illegal_inst(illegal_inst),
    .underflow_err(underflow_err), .dbg(dbg)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check at the falling edge, then advance past the rising edge.
  task automatic step(input logic v, input logic [1:0] c, input logic rd,
                      input logic cm, input logic rsf, input logic lsf, input logic fl,
                      input logic exp_acc, input logic exp_fl, input string tag);
    logic [31:0] exp_tag;
    inst_valid  = v;
    inst_class  = c;
    inst_has_rd = rd;
    rob_commit  = cm;
    rs_free     = rsf;
    lsb_free    = lsf;
    flush       = fl;
    if (exp_acc) begin
      exp_q.push_back(ROB_TAG_W'(tail_m));
      tail_m = (tail_m + 1) % ROB_DEPTH;
    end
    @(negedge clk);
    chk({tag, ".accept"}, inst_accept, exp_acc);
    chk({tag, ".alloc"}, {rob_alloc, rs_alloc, lsb_alloc, rat_write},
        exp_acc ? {1'b1, c != CLASS_MEM, c == CLASS_MEM, rd} : 4'b0000);
    chk({tag, ".flushing"}, flushing, exp_fl);
    if (inst_accept === 1'b1) begin
      exp_tag = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hffff_ffff;
      chk({tag, ".tag"}, rob_tail_tag, exp_tag);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    clr = 1'b1; rdy = 1'b1;
    inst_valid = 0; inst_class = CLASS_ALU; inst_has_rd = 0;
    rob_commit = 0; rs_free = 0; lsb_free = 0; flush = 0;
    @(negedge clk);
    chk("rst.accept", inst_accept, 0);
    chk("rst.alloc", {rob_alloc, rs_alloc, lsb_alloc, rat_write}, 0);
    chk("rst.tag", rob_tail_tag, 0);
    chk("rst.flags", {flushing, illegal_inst, underflow_err}, 0);
    chk("rst.state", dbg.state, ST_IDLE);
    @(posedge clk);
    #1;
    clr = 1'b0;

    // IDLE cycle, then three ALU accepts with tags 0..2
    step(1, CLASS_ALU, 1, 0, 0, 0, 0, 0, 0, "idle");
    chk("run.state", dbg.state, ST_RUN);
    for (int i = 0; i < 3; i++) step(1, CLASS_ALU, 1, 0, 0, 0, 0, 1, 0, "alu3");

    // fill RS to 8, then RS-full boundary
    for (int i = 0; i < 5; i++) step(1, CLASS_BR, 0, 0, 0, 0, 0, 1, 0, "rsfill");
    step(1, CLASS_ALU, 1, 0, 0, 0, 0, 0, 0, "rsfull_blk");
    step(1, CLASS_MEM, 0, 0, 0, 0, 0, 1, 0, "rsfull_mem");
    step(1, CLASS_ALU, 1, 0, 1, 0, 0, 0, 0, "rsfull_free");
    step(1, CLASS_ALU, 1, 0, 0, 0, 0, 1, 0, "rs_after_free");
    step(0, CLASS_ALU, 0, 0, 1, 0, 0, 0, 0, "rs_free7");
    step(1, CLASS_ALU, 1, 0, 1, 0, 0, 1, 0, "rs_alloc_free");
    step(1, CLASS_ALU, 1, 0, 0, 0, 0, 1, 0, "rs_to8");
    step(1, CLASS_ALU, 1, 0, 0, 0, 0, 0, 0, "rs_still8");

    // fill the ROB to 16 with MEM traffic; tail wraps to 0
    for (int i = 0; i < 4; i++) step(1, CLASS_MEM, 1, 0, 0, 0, 0, 1, 0, "robfill");
    step(1, CLASS_MEM, 1, 0, 0, 0, 0, 0, 0, "robfull_blk");
    step(1, CLASS_MEM, 1, 1, 0, 0, 0, 0, 0, "robfull_commit");
    step(1, CLASS_MEM, 1, 0, 0, 0, 0, 1, 0, "rob_wrap");

    // flush with valid and commit; frees during FLUSH must be ignored
    step(1, CLASS_ALU, 1, 1, 0, 0, 1, 0, 0, "flush_req");
    tail_m = 0;
    chk("flush.state", dbg.state, ST_FLUSH);
    step(1, CLASS_ALU, 1, 1, 1, 1, 0, 0, 1, "flush_c1");
    step(1, CLASS_ALU, 1, 0, 0, 0, 0, 0, 1, "flush_c2");
    chk("flush.counts", {dbg.rob_empty, dbg.rs_empty, dbg.lsb_empty}, 3'b111);
    chk("flush.no_uf", underflow_err, 0);
    step(1, CLASS_ALU, 1, 0, 0, 0, 0, 1, 0, "post_flush");

    // underflow on an RS free at zero; count must stay at 0
    step(0, CLASS_ALU, 0, 0, 1, 0, 0, 0, 0, "rs_to0");
    chk("uf.before", underflow_err, 0);
    step(0, CLASS_ALU, 0, 0, 1, 0, 0, 0, 0, "rs_free_at0");
    chk("uf.set", underflow_err, 1);
    chk("uf.rs_empty", dbg.rs_empty, 1);
    step(1, CLASS_ALU, 0, 0, 0, 0, 0, 1, 0, "uf_accept");
    chk("uf.sticky", underflow_err, 1);

    // rdy low: outputs gated, flush ignored
    rdy = 1'b0;
    step(1, CLASS_ALU, 1, 0, 0, 0, 1, 0, 0, "rdy_low");
    chk("rdylow.gated", {underflow_err, rob_tail_tag}, 0);
    rdy = 1'b1;
    step(1, CLASS_ALU, 1, 0, 0, 0, 0, 1, 0, "rdy_back");

    // illegal class stalls; flush then clr mid-FLUSH
    step(1, CLASS_ILL, 1, 0, 0, 0, 0, 0, 0, "ill");
    chk("ill.flag", illegal_inst, 1);
    step(1, CLASS_ILL, 1, 0, 0, 0, 0, 0, 0, "ill_stall");
    step(1, CLASS_ILL, 1, 0, 0, 0, 1, 0, 0, "ill_flush");
    inst_valid = 0; flush = 0;
    #1;
    chk("midflush.flushing", flushing, 1);
    clr = 1'b1;
    #1;
    chk("clr.flushing", flushing, 0);
    chk("clr.flags", {illegal_inst, underflow_err}, 0);
    chk("clr.state", dbg.state, ST_IDLE);
    @(posedge clk);
    #1;
    clr = 1'b0;
    tail_m = 0;
    step(1, CLASS_ALU, 1, 0, 0, 0, 0, 0, 0, "clr_idle");
    step(1, CLASS_ALU, 1, 0, 0, 0, 0, 1, 0, "clr_first");

    chk("sb.drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
